// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - tagged request FIFO and multicycle issue engine for the 16-bit divider
// Holds registered operands for DIV_CYCLES, then returns quotient/remainder (or dbz result) over valid/ready.
module div_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4,
  parameter int DIV_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_lop,
  input  logic [15:0]      req_rop,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      div_lop,
  output logic [15:0]      div_rop,
  input  logic [15:0]      div_quot,
  input  logic [15:0]      div_mod,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [15:0]      resp_quot,
  output logic [15:0]      resp_mod,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_dbz,
  output logic [7:0]       dbz_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + TAG_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    CNT_INIT = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EVAL, DZ, DONE} state_e;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      div_lop_q, div_lop_d, div_rop_q, div_rop_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      resp_quot_q, resp_quot_d, resp_mod_q, resp_mod_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_dbz_q, resp_dbz_d;
  logic [7:0]       dbz_cnt_q, dbz_cnt_d;

  logic             full, empty, push, pop;
  logic [EW-1:0]    head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {req_tag, req_lop, req_rop};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_lop_d   = div_lop_q;
    div_rop_d   = div_rop_q;
    tag_d       = tag_q;
    resp_quot_d = resp_quot_q;
    resp_mod_d  = resp_mod_q;
    resp_tag_d  = resp_tag_q;
    resp_dbz_d  = resp_dbz_q;
    dbz_cnt_d   = dbz_cnt_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: pop = !empty;
      EVAL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_quot_d = div_quot;
          resp_mod_d  = div_mod;
          resp_tag_d  = tag_q;
          resp_dbz_d  = 1'b0;
          state_d     = DONE;
        end
      end
      DZ: begin
        // Mirrors the divider's native rop=0 output without waiting on it
        resp_quot_d = 16'hFFFF;
        resp_mod_d  = div_lop_q;
        resp_tag_d  = tag_q;
        resp_dbz_d  = 1'b1;
        if (dbz_cnt_q != 8'hFF) dbz_cnt_d = dbz_cnt_q + 8'd1;
        state_d = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      div_lop_d = head[31:16];
      div_rop_d = head[15:0];
      tag_d     = head[EW-1:32];
      cnt_d     = CNT_INIT;
      state_d   = (head[15:0] == 16'd0) ? DZ : EVAL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_lop_q   <= '0;
      div_rop_q   <= '0;
      tag_q       <= '0;
      resp_quot_q <= '0;
      resp_mod_q  <= '0;
      resp_tag_q  <= '0;
      resp_dbz_q  <= 1'b0;
      dbz_cnt_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_lop_q   <= div_lop_d;
      div_rop_q   <= div_rop_d;
      tag_q       <= tag_d;
      resp_quot_q <= resp_quot_d;
      resp_mod_q  <= resp_mod_d;
      resp_tag_q  <= resp_tag_d;
      resp_dbz_q  <= resp_dbz_d;
      dbz_cnt_q   <= dbz_cnt_d;
    end
  end

  assign div_lop    = div_lop_q;
  assign div_rop    = div_rop_q;
  assign resp_valid = (state_q == DONE);
  assign resp_quot  = resp_quot_q;
  assign resp_mod   = resp_mod_q;
  assign resp_tag   = resp_tag_q;
  assign resp_dbz   = resp_dbz_q;
  assign dbz_cnt    = dbz_cnt_q;
endmodule
